// File: rtl/cpu_defs.sv
// Shared constants and next-PC source encoding for the MIPS fetch front end.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC   = 32'hBFC0_0380;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    BR   = 3'd1,
    J    = 3'd2,
    JR   = 3'd3,
    PEND = 3'd4,
    EXC  = 3'd5,
    ERET = 3'd6
  } npc_src_e;

endpackage

// File: rtl/fetch_pc_npc_sel.sv
// Next-PC priority mux with branch/jump target adders; purely combinational.
module npc_sel
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  output npc_src_e    src,
  output logic [31:0] target,
  output logic [31:0] next_pc
);

  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_seq_pc;

  assign w_br_target = branch_base + branch_offset;
  assign w_j_target  = {branch_base[31:28], jump_index, 2'b00};
  assign w_seq_pc    = pc + 32'd4;

  always_comb begin
    src    = SEQ;
    target = w_seq_pc;
    if (exc_req) begin
      src    = EXC;
      target = EXC_PC;
    end else if (eret) begin
      src    = ERET;
      target = epc;
    end else if (pend_valid) begin
      src    = PEND;
      target = pend_target;
    end else if (jr) begin
      src    = JR;
      target = jr_target;
    end else if (jump) begin
      src    = J;
      target = w_j_target;
    end else if (branch_taken) begin
      src    = BR;
      target = w_br_target;
    end
  end

  // A stall refetches the current word unless an exception/eret forces a redirect.
  assign next_pc = (stall && !exc_req && !eret) ? pc : target;

endmodule

// File: rtl/fetch_pc.sv
// IF stage: PC register, stalled-redirect buffer and instruction SRAM drive.
module fetch_pc
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_adel
);

  logic [31:0] r_pc;
  logic        r_valid;
  logic        r_adel;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  npc_src_e    w_src;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic        w_redirect;

  npc_sel u_npc_sel (
    .pc            (r_pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .exc_req       (exc_req),
    .eret          (eret),
    .epc           (epc),
    .pend_valid    (r_pend_valid),
    .pend_target   (r_pend_target),
    .src           (w_src),
    .target        (w_target),
    .next_pc       (w_next_pc)
  );

  // JR/J/BR can only win the mux when the buffer is empty, so first redirect wins.
  assign w_redirect = (w_src == JR) || (w_src == J) || (w_src == BR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC - 32'd4;
      r_valid       <= 1'b0;
      r_adel        <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0;
    end else begin
      r_pc    <= w_next_pc;
      r_valid <= 1'b1;
      r_adel  <= (w_next_pc[1:0] != 2'b00);
      if (exc_req || eret) begin
        r_pend_valid <= 1'b0;
      end else if (stall) begin
        if (w_redirect) begin
          r_pend_valid  <= 1'b1;
          r_pend_target <= w_target;
        end
      end else begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign inst_sram_addr = w_next_pc;
  assign inst_sram_en   = !rst && (w_next_pc[1:0] == 2'b00);
  assign if_pc          = r_pc;
  assign if_inst        = r_adel ? 32'h0 : inst_sram_rdata;
  assign if_valid       = r_valid;
  assign if_adel        = r_adel;

endmodule
